// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared execute-stage types for the multiplier issue path
package core_pkg;

  typedef enum logic [1:0] {
    MUL_LO = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_opcode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } mul_issue_state_t;

endpackage

// File: rtl/mul_issue.sv
// rtl/mul_issue.sv - single-entry issue/collect stage in front of the integer multiplier
module mul_issue
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            flush,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [1:0]      dec_opcode,
  input  logic [XLEN-1:0] dec_op1,
  input  logic [XLEN-1:0] dec_op2,
  input  logic [RW-1:0]   dec_rd,
  output logic            mul_in_valid,
  input  logic            mul_in_ready,
  output logic [1:0]      mul_opcode,
  output logic [XLEN-1:0] mul_op1,
  output logic [XLEN-1:0] mul_op2,
  input  logic            mul_out_valid,
  input  logic [XLEN-1:0] mul_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data
);

  mul_issue_state_t state, state_nxt;
  mul_opcode_t      opcode_q;
  logic [XLEN-1:0]  op1_q, op2_q, data_q;
  logic [RW-1:0]    rd_q;
  logic             take_op, take_res;

  always_comb begin
    state_nxt    = state;
    dec_ready    = 1'b0;
    mul_in_valid = 1'b0;
    wb_valid     = 1'b0;
    take_op      = 1'b0;
    take_res     = 1'b0;
    case (state)
      IDLE: begin
        dec_ready = !flush;
        if (dec_valid && !flush) begin
          take_op   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Withheld under flush so the MUL never starts an op we are about to forget.
        mul_in_valid = !flush;
        if (flush) begin
          state_nxt = IDLE;
        end else if (mul_in_ready) begin
          if (mul_out_valid) begin
            take_res  = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // A result landing in the flush cycle is already consumed, so no drain needed.
        if (flush) begin
          state_nxt = mul_out_valid ? IDLE : DRAIN;
        end else if (mul_out_valid) begin
          take_res  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        wb_valid  = 1'b1;
        dec_ready = wb_ready && !flush;
        if (flush) begin
          state_nxt = IDLE;
        end else if (wb_ready) begin
          if (dec_valid) begin
            take_op   = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DRAIN: begin
        if (mul_out_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state    <= IDLE;
      opcode_q <= MUL_LO;
      op1_q    <= '0;
      op2_q    <= '0;
      rd_q     <= '0;
      data_q   <= '0;
    end else begin
      state <= state_nxt;
      if (take_op) begin
        opcode_q <= mul_opcode_t'(dec_opcode);
        op1_q    <= dec_op1;
        op2_q    <= dec_op2;
        rd_q     <= dec_rd;
      end
      if (take_res) data_q <= mul_result;
    end
  end

  assign mul_opcode = opcode_q;
  assign mul_op1    = op1_q;
  assign mul_op2    = op2_q;
  assign wb_rd      = rd_q;
  assign wb_data    = data_q;

endmodule

// File: tb/tb_mul_issue.sv
// tb/tb_mul_issue.sv - randomized scoreboard bench for mul_issue with a stub multiplier
module tb_mul_issue;

  logic        clk;
  logic        rst_b, flush;
  logic        dec_valid, dec_ready;
  logic [1:0]  dec_opcode;
  logic [31:0] dec_op1, dec_op2;
  logic [4:0]  dec_rd;
  logic        mul_in_valid, mul_in_ready;
  logic [1:0]  mul_opcode;
  logic [31:0] mul_op1, mul_op2;
  logic        mul_out_valid;
  logic [31:0] mul_result;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mul_issue #(.XLEN(32), .RW(5)) dut (
    .clk(clk), .rst_b(rst_b), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_op1(dec_op1), .dec_op2(dec_op2), .dec_rd(dec_rd),
    .mul_in_valid(mul_in_valid), .mul_in_ready(mul_in_ready), .mul_opcode(mul_opcode),
    .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_out_valid(mul_out_valid), .mul_result(mul_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } op_t;

  op_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc_n = 0;

  // Stub multiplier: lat=0 answers combinationally, otherwise lat cycles after acceptance.
  int          lat = 0, cnt = 0, stall_left = 0, stall_cfg = 0;
  bit          pend = 0;
  logic [31:0] pres = '0;

  logic s_dec_ready, s_in_valid, s_in_ready, s_out_valid, s_wb_valid;

  function automatic logic [31:0] ref_mul(logic [1:0] opc, logic [31:0] a, logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (opc == 2'b01 || opc == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    xb = (opc == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = xa * xb;
    return (opc == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic set_op(logic [1:0] opc, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
    dec_valid  = 1'b1;
    dec_opcode = opc;
    dec_op1    = a;
    dec_op2    = b;
    dec_rd     = rd;
  endtask

  // One clock: drive stub, sample outputs, run the scoreboard, then advance to the next negedge.
  task automatic tick();
    op_t o;
    mul_in_ready = (stall_left == 0);
    #1;
    if (lat == 0) begin
      mul_out_valid = mul_in_valid && mul_in_ready;
      mul_result    = ref_mul(mul_opcode, mul_op1, mul_op2);
    end else begin
      mul_out_valid = pend && (cnt == 1);
      mul_result    = pres;
    end
    #1;
    s_dec_ready = dec_ready;
    s_in_valid  = mul_in_valid;
    s_in_ready  = mul_in_ready;
    s_out_valid = mul_out_valid;
    s_wb_valid  = wb_valid;
    if (rst_b) begin
      exp_q.delete();
    end else begin
      if (flush) chk("dec_ready_in_flush", s_dec_ready, 0);
      if (s_out_valid) chk("out_valid_in_done", s_wb_valid, 0);
      if (s_in_valid) begin
        if (exp_q.size() == 0) chk("issue_without_op", 1, 0);
        else begin
          o = exp_q[0];
          chk("issue_operands", {mul_opcode, mul_op1, mul_op2}, {o.opc, o.a, o.b});
        end
      end
      if (s_wb_valid && wb_ready && !flush) begin
        if (exp_q.size() == 0) chk("wb_without_op", 1, 0);
        else begin
          o = exp_q.pop_front();
          chk("wb_rd", wb_rd, o.rd);
          chk("wb_data", wb_data, ref_mul(o.opc, o.a, o.b));
        end
      end
      if (flush) exp_q.delete();
      if (dec_valid && s_dec_ready) begin
        o.opc = dec_opcode; o.a = dec_op1; o.b = dec_op2; o.rd = dec_rd;
        exp_q.push_back(o);
      end
    end
    @(posedge clk);
    if (rst_b) begin
      pend = 0; cnt = 0; stall_left = 0;
    end else begin
      if (s_in_valid && !s_in_ready) stall_left--;
      if (pend) begin
        if (cnt == 1) pend = 0;
        cnt--;
      end
      if (s_in_valid && s_in_ready) begin
        stall_left = stall_cfg;
        if (lat > 0) begin
          pend = 1;
          cnt  = lat;
          pres = ref_mul(mul_opcode, mul_op1, mul_op2);
        end
      end
    end
    cyc_n++;
    @(negedge clk);
  endtask

  initial begin
    int stalls, waits, ovc, wbc, seen_wb;
    rst_b = 1'b1; flush = 1'b0; dec_valid = 1'b0; dec_opcode = '0;
    dec_op1 = '0; dec_op2 = '0; dec_rd = '0; wb_ready = 1'b1;
    mul_in_ready = 1'b1; mul_out_valid = 1'b0; mul_result = '0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_wb_valid", s_wb_valid, 0);
    chk("rst_in_valid", s_in_valid, 0);
    chk("rst_dec_ready", s_dec_ready, 1);
    chk("rst_data_regs", {wb_rd, wb_data, mul_op1, mul_op2}, 0);
    rst_b = 1'b0;

    // Single-cycle MUL latency
    set_op(2'b00, 32'd3, 32'hFFFF_FFFE, 5'd7);
    tick();
    chk("t1_accept", s_dec_ready, 1);
    dec_valid = 1'b0;
    tick();
    chk("t1_issue", {s_in_valid, s_wb_valid}, 2'b10);
    tick();
    chk("t1_wb_valid", s_wb_valid, 1);
    chk("t1_wb", {wb_rd, wb_data}, {5'd7, 32'hFFFF_FFFA});
    tick();
    chk("t1_idle", {s_dec_ready, s_wb_valid, s_in_valid}, 3'b100);

    // Back-to-back handoff from DONE
    set_op(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1);
    tick();
    dec_valid = 1'b0;
    tick();
    set_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    tick();
    chk("t2_first", {s_wb_valid, s_dec_ready, wb_data}, {2'b11, 32'h4000_0000});
    dec_valid = 1'b0;
    tick();
    tick();
    chk("t2_second", {s_wb_valid, wb_rd, wb_data}, {1'b1, 5'd2, 32'hFFFF_FFFE});
    tick();

    // Writeback backpressure
    set_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    tick();
    wb_ready = 1'b0;
    set_op(2'b00, 32'd1, 32'd1, 5'd4);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold", {s_wb_valid, s_dec_ready, wb_data}, {2'b10, 32'hFFFF_FFFF});
    end
    dec_valid = 1'b0;
    wb_ready = 1'b1;
    tick();
    chk("t3_release", s_wb_valid, 1);
    tick();
    chk("t3_idle", {s_dec_ready, s_wb_valid}, 2'b10);

    // Multicycle MUL with input stall
    lat = 4; stall_left = 2; stall_cfg = 0;
    set_op(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9);
    tick();
    dec_valid = 1'b0;
    stalls = 0; waits = 0; ovc = -1; wbc = -1;
    for (int i = 0; i < 30 && wbc < 0; i++) begin
      tick();
      if (s_in_valid && !s_in_ready) stalls++;
      if (!s_in_valid && !s_wb_valid && !s_dec_ready) waits++;
      if (s_out_valid) ovc = cyc_n;
      if (s_wb_valid) wbc = cyc_n;
    end
    chk("t4_stall_cycles", stalls, 2);
    chk("t4_wait_cycles", waits, 4);
    chk("t4_wb_seen", wbc >= 0, 1);
    chk("t4_wb_after_ov", wbc - ovc, 1);
    tick();

    // Flush while the multiply is outstanding
    set_op(2'b00, 32'd7, 32'd8, 5'd4);
    tick();
    dec_valid = 1'b0;
    tick();
    tick();
    chk("t5_wait", s_in_valid, 0);
    flush = 1'b1; wb_ready = 1'b0;
    tick();
    flush = 1'b0; wb_ready = 1'b1;
    seen_wb = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) chk("t5_drain_ready", s_dec_ready, 0);
      if (s_wb_valid) seen_wb++;
    end
    chk("t5_no_wb", seen_wb, 0);
    chk("t5_idle", s_dec_ready, 1);
    lat = 0;
    set_op(2'b00, 32'd5, 32'd6, 5'd6);
    tick();
    dec_valid = 1'b0;
    tick();
    tick();
    chk("t5_next_op", {s_wb_valid, wb_data}, {1'b1, 32'd30});
    tick();

    // Reset while holding a result
    wb_ready = 1'b0;
    set_op(2'b00, 32'd9, 32'd9, 5'd8);
    tick();
    dec_valid = 1'b0;
    tick();
    tick();
    chk("t6_done", s_wb_valid, 1);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    tick();
    chk("t6_after_rst", {s_wb_valid, s_dec_ready, s_in_valid}, 3'b010);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst_b = ($urandom_range(0, 199) == 0);
      flush = !rst_b && ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) < 6)
        set_op(2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)));
      else
        dec_valid = 1'b0;
      wb_ready  = !flush && ($urandom_range(0, 9) < 7);
      stall_cfg = $urandom_range(0, 2);
      if (exp_q.size() == 0 && !pend) lat = $urandom_range(0, 5);
      tick();
    end
    rst_b = 1'b0; flush = 1'b0; dec_valid = 1'b0; wb_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_issue.md
Name: mul_issue

Overview:
- Issue/collect stage directly upstream of the integer multiplier (MUL) in the core_s execute path.
- Accepts one multiply op plus destination register from decode and drives MUL through its in_valid/in_ready handshake.
- Captures the MUL result, whether it returns in the same cycle or several cycles later, and presents {rd, data} to writeback with a valid/ready handshake.
- Supports flush, including flush while a multicycle multiply is outstanding.

Parameters:
- XLEN, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset; synchronous, active-high (rst_b=1 resets on the clk rising edge).
- flush  in  1  kill the in-flight op; no writeback is produced for it.
- dec_valid  in  1  decode offers an op.
- dec_ready  out  1  this block accepts the op.
- dec_opcode  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- dec_op1  in  XLEN  rs1 value.
- dec_op2  in  XLEN  rs2 value.
- dec_rd  in  RW  destination register.
- mul_in_valid  out  1  to MUL in_valid.
- mul_in_ready  in  1  from MUL in_ready.
- mul_opcode  out  2  to MUL opcode.
- mul_op1  out  XLEN  to MUL op1.
- mul_op2  out  XLEN  to MUL op2.
- mul_out_valid  in  1  from MUL out_valid.
- mul_result  in  XLEN  from MUL result.
- wb_valid  out  1  result available to writeback.
- wb_ready  in  1  writeback accepts.
- wb_rd  out  RW  destination register.
- wb_data  out  XLEN  product.

Behaviour:
- One op in flight at a time.
- Registers: opcode, op1, op2, rd, data, and a 3-bit state.
- The mul_* operand outputs are driven from the registers.
- Reset:
  - state=IDLE, wb_valid=0, mul_in_valid=0, dec_ready=1.
  - All data registers are cleared to 0.
- Reset mid-operation abandons everything. The MUL is assumed reset on the same signal.
- States:
  - IDLE:
    - dec_ready=1.
    - dec_valid captures opcode, op1, op2, rd and moves to ISSUE.
  - ISSUE:
    - mul_in_valid=1.
    - If mul_in_ready and mul_out_valid are both high (single-cycle MUL), capture mul_result into data and move to DONE.
    - If mul_in_ready=1 and mul_out_valid=0, move to WAIT.
    - If mul_in_ready=0, hold with operands stable.
  - WAIT:
    - mul_in_valid=0.
    - On mul_out_valid, capture data and move to DONE.
    - No timeout.
  - DONE:
    - wb_valid=1; wb_rd and wb_data come from the registers.
    - dec_ready=wb_ready, which gives a back-to-back handoff.
    - wb_ready&&dec_valid: capture the new op and go to ISSUE.
    - wb_ready only: go to IDLE.
    - Otherwise hold, and wb_* stays stable.
  - DRAIN:
    - Entered when flush is seen in WAIT.
    - dec_ready=0.
    - The next mul_out_valid is discarded and the state goes to IDLE.
- Flush (highest priority):
  - In ISSUE or DONE, go to IDLE. wb_valid=0 from the next cycle.
  - In WAIT, go to DRAIN.
  - In IDLE, ignored.
  - In DRAIN, state is unchanged.
  - dec_valid in the flush cycle is not accepted; dec_ready is forced to 0 while flush=1.
- Latency with single-cycle MUL:
  - Accept at cycle N, ISSUE at N+1, wb_valid at N+2.
  - Throughput is 1 op per 2 cycles.
- Multicycle MUL with k-cycle delay: wb_valid comes 1 cycle after mul_out_valid.
- rd=0: the result is still presented to writeback, which ignores x0.
- mul_out_valid arriving in IDLE or DONE is a protocol error and is ignored. The bench asserts it never occurs.
- wb_data equals mul_result bit-exact; no further arithmetic in this block.

Decomposition:
- Shared package core_pkg holds:
  - mul_opcode_t enum (MUL_LO=2'b00, MULH=2'b01, MULHSU=2'b10, MULHU=2'b11).
  - mul_issue_state_t enum (IDLE, ISSUE, WAIT, DONE, DRAIN).
- No sub-module. MUL is instantiated beside this block by the execute-stage parent.

Test Plan:
- MUL_LO, op1=3, op2=0xFFFFFFFE, rd=7, single-cycle MUL, wb_ready=1 -> wb_valid at N+2, wb_rd=7, wb_data=0xFFFFFFFA, back in IDLE at N+3.
- MULH 0x80000000×0x80000000, then MULHU 0xFFFFFFFF×0xFFFFFFFF back-to-back with wb_ready=1 -> wb_data=0x40000000 then 0xFFFFFFFE, second op accepted in the DONE cycle.
- MULHSU op1=0xFFFFFFFF, op2=0xFFFFFFFF, wb_ready held 0 for 5 cycles -> wb_valid stays 1, wb_data=0xFFFFFFFF stable, dec_ready=0, released on wb_ready.
- Stub MUL with 4-cycle delay and in_ready low for 2 cycles -> operands stable during stall, WAIT entered, wb_valid exactly 1 cycle after mul_out_valid.
- Flush in WAIT with 4-cycle stub -> DRAIN, the late mul_out_valid is dropped, no wb_valid, next op (MUL 5×6) returns wb_data=30.
- rst_b=1 asserted in DONE with wb_ready=0 -> next cycle wb_valid=0, dec_ready=1, state IDLE.
